// File: rtl/adder_tree_pkg.sv
// ============================================================================
// Module : adder_tree_pkg
// Brief  : Width helpers and level-registration predicate for the adder tree.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int sum_w(input int adder_width, input int num_inputs);
        return adder_width + clog2(num_inputs);
    endfunction

    function automatic int acc_w(input int adder_width, input int num_inputs, input int acc_bits);
        return sum_w(adder_width, num_inputs) + acc_bits;
    endfunction

    // The last level is always registered so the accumulator sees a clean input.
    function automatic bit is_reg_level(input int k, input int l, input int stride);
        return ((k % stride) == 0) || (k == l);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_tree_level.sv
// ============================================================================
// Module : adder_tree_level
// Brief  : One tree level: adds adjacent operand pairs, optionally registered.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_tree_level #(
    parameter int IN_W       = 13,
    parameter int N_PAIRS    = 4,
    parameter int REGISTERED = 1,
    parameter int SIGNED     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [2*N_PAIRS*IN_W-1:0]      in_vec,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic [N_PAIRS*(IN_W+1)-1:0]    out_vec,
    output logic                           out_valid,
    output logic                           out_last
);

    localparam int OUT_W = IN_W + 1;

    logic [N_PAIRS*OUT_W-1:0] w_sum;

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
        logic [IN_W-1:0]  w_a;
        logic [IN_W-1:0]  w_b;
        logic [OUT_W-1:0] w_a_ext;
        logic [OUT_W-1:0] w_b_ext;

        assign w_a     = in_vec[(2*p)*IN_W +: IN_W];
        assign w_b     = in_vec[(2*p+1)*IN_W +: IN_W];
        assign w_a_ext = (SIGNED != 0) ? {w_a[IN_W-1], w_a} : {1'b0, w_a};
        assign w_b_ext = (SIGNED != 0) ? {w_b[IN_W-1], w_b} : {1'b0, w_b};
        assign w_sum[p*OUT_W +: OUT_W] = w_a_ext + w_b_ext;
    end

    if (REGISTERED != 0) begin : g_reg
        logic [N_PAIRS*OUT_W-1:0] r_vec;
        logic                     r_valid;
        logic                     r_last;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (en) begin
                r_valid <= in_valid;
                r_last  <= in_last;
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                r_vec <= w_sum;
            end
        end

        assign out_vec   = r_vec;
        assign out_valid = r_valid;
        assign out_last  = r_last;
    end else begin : g_comb
        assign out_vec   = w_sum;
        assign out_valid = in_valid;
        assign out_last  = in_last;
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder_tree.sv
// ============================================================================
// Module : pipelined_adder_tree
// Brief  : Balanced pipelined adder tree with packet accumulator and handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter  int ADDER_WIDTH = 13,
    parameter  int NUM_INPUTS  = 8,
    parameter  int SIGNED      = 0,
    parameter  int PIPE_STRIDE = 1,
    parameter  int ACC_BITS    = 4,
    localparam int L           = clog2(NUM_INPUTS),
    localparam int SUM_W       = sum_w(ADDER_WIDTH, NUM_INPUTS),
    localparam int ACC_W       = acc_w(ADDER_WIDTH, NUM_INPUTS, ACC_BITS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [ACC_W-1:0]                  out_data,
    output logic                              out_ovf,
    output logic                              out_valid,
    input  logic                              out_ready
);

    logic                              w_en;
    logic [NUM_INPUTS*ADDER_WIDTH-1:0] r_s0_data;
    logic                              r_s0_valid;
    logic                              r_s0_last;

    logic [SUM_W-1:0]                  w_tree_sum;
    logic                              w_tree_valid;
    logic                              w_tree_last;
    logic [ACC_W-1:0]                  w_tree_ext;
    logic [ACC_W:0]                    w_sum_full;
    logic [ACC_W-1:0]                  w_s;
    logic                              w_s_ovf;

    logic [ACC_W-1:0]                  r_acc;
    logic                              r_ovf_q;
    logic [ACC_W-1:0]                  r_out_data;
    logic                              r_out_ovf;
    logic                              r_out_valid;

    // One enable for the whole pipe: everything freezes while a result waits.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else if (w_en) begin
            r_s0_valid <= in_valid;
            r_s0_last  <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s0_data <= in_data;
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_level
        localparam int IN_W    = ADDER_WIDTH + k - 1;
        localparam int N_PAIRS = NUM_INPUTS >> k;

        logic [2*N_PAIRS*IN_W-1:0]   w_in_vec;
        logic                        w_in_valid;
        logic                        w_in_last;
        logic [N_PAIRS*(IN_W+1)-1:0] w_out_vec;
        logic                        w_out_valid;
        logic                        w_out_last;

        if (k == 1) begin : g_first
            assign w_in_vec   = r_s0_data;
            assign w_in_valid = r_s0_valid;
            assign w_in_last  = r_s0_last;
        end else begin : g_chain
            assign w_in_vec   = g_level[k-1].w_out_vec;
            assign w_in_valid = g_level[k-1].w_out_valid;
            assign w_in_last  = g_level[k-1].w_out_last;
        end

        adder_tree_level #(
            .IN_W       (IN_W),
            .N_PAIRS    (N_PAIRS),
            .REGISTERED (int'(is_reg_level(k, L, PIPE_STRIDE))),
            .SIGNED     (SIGNED)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (w_en),
            .in_vec    (w_in_vec),
            .in_valid  (w_in_valid),
            .in_last   (w_in_last),
            .out_vec   (w_out_vec),
            .out_valid (w_out_valid),
            .out_last  (w_out_last)
        );
    end

    assign w_tree_sum   = g_level[L].w_out_vec;
    assign w_tree_valid = g_level[L].w_out_valid;
    assign w_tree_last  = g_level[L].w_out_last;

    always_comb begin
        if (SIGNED != 0) begin
            w_tree_ext = ACC_W'($signed(w_tree_sum));
        end else begin
            w_tree_ext = ACC_W'(w_tree_sum);
        end
        w_sum_full = {1'b0, r_acc} + {1'b0, w_tree_ext};
        w_s        = w_sum_full[ACC_W-1:0];
        if (SIGNED != 0) begin
            w_s_ovf = (r_acc[ACC_W-1] == w_tree_ext[ACC_W-1]) && (w_s[ACC_W-1] != r_acc[ACC_W-1]);
        end else begin
            w_s_ovf = w_sum_full[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf_q     <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            if (w_tree_valid && w_tree_last) begin
                r_out_data  <= w_s;
                r_out_ovf   <= r_ovf_q | w_s_ovf;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_ovf_q     <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
                if (w_tree_valid) begin
                    r_acc   <= w_s;
                    r_ovf_q <= r_ovf_q | w_s_ovf;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
// ============================================================================
// Module : tb_pipelined_adder_tree
// Brief  : Scoreboard bench driving unsigned, signed and zero-headroom instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_adder_tree;

    localparam int AW = 13;
    localparam int NI = 8;
    localparam int DW = AW * NI;

    typedef struct {
        logic [19:0] du;
        logic [19:0] ds;
        logic [15:0] da;
        bit          ou;
        bit          os;
        bit          oa;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic          in_ready, in_ready_s, in_ready_a;
    logic [19:0]   out_data, out_data_s;
    logic [15:0]   out_data_a;
    logic          out_ovf, out_ovf_s, out_ovf_a;
    logic          out_valid, out_valid_s, out_valid_a;

    int            vectors;
    int            miscompares;
    int            rdy_mode;
    exp_t          sb[$];
    longint        m_acc[3];
    bit            m_ovq[3];

    pipelined_adder_tree u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    pipelined_adder_tree #(.SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_s), .out_data(out_data_s), .out_ovf(out_ovf_s),
        .out_valid(out_valid_s), .out_ready(out_ready)
    );

    pipelined_adder_tree #(.ACC_BITS(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_ovf(out_ovf_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: wide integer accumulate, then wrap to w bits and flag range escape.
    function automatic void acc_step(input longint acc, input longint bsum, input int w,
                                     input bit sgn, output longint nacc, output bit ovf);
        longint m, s, u;
        m    = longint'(1) << w;
        s    = acc + bsum;
        ovf  = sgn ? ((s < -(m / 2)) || (s >= (m / 2))) : (s >= m);
        u    = ((s % m) + m) % m;
        nacc = (sgn && (u >= (m / 2))) ? (u - m) : u;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_acc[j] = 0;
            m_ovq[j] = 1'b0;
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic last);
        longint bsum[3];
        longint nacc[3];
        bit     ovf[3];
        longint op;
        exp_t   e;
        bsum = '{0, 0, 0};
        for (int i = 0; i < NI; i++) begin
            op = longint'(d[i*AW +: AW]);
            bsum[0] += op;
            bsum[1] += (op >= 4096) ? (op - 8192) : op;
            bsum[2] += op;
        end
        acc_step(m_acc[0], bsum[0], 20, 1'b0, nacc[0], ovf[0]);
        acc_step(m_acc[1], bsum[1], 20, 1'b1, nacc[1], ovf[1]);
        acc_step(m_acc[2], bsum[2], 16, 1'b0, nacc[2], ovf[2]);
        if (last) begin
            e.du = nacc[0][19:0];
            e.ds = nacc[1][19:0];
            e.da = nacc[2][15:0];
            e.ou = m_ovq[0] | ovf[0];
            e.os = m_ovq[1] | ovf[1];
            e.oa = m_ovq[2] | ovf[2];
            sb.push_back(e);
            model_reset();
        end else begin
            for (int j = 0; j < 3; j++) begin
                m_acc[j] = nacc[j];
                m_ovq[j] = m_ovq[j] | ovf[j];
            end
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*AW +: AW] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n;
        bit ok;
        n        = 0;
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end else begin
            model_accept(d, last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle a result is shown it must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got data=%0h expected no result", out_data);
                end else begin
                    e = sb[0];
                    chk("data_unsigned", 64'(out_data), 64'(e.du));
                    chk("ovf_unsigned", 64'(out_ovf), 64'(e.ou));
                    chk("valid_signed", 64'(out_valid_s), 64'd1);
                    chk("data_signed", 64'(out_data_s), 64'(e.ds));
                    chk("ovf_signed", 64'(out_ovf_s), 64'(e.os));
                    chk("valid_acc0", 64'(out_valid_a), 64'd1);
                    chk("data_acc0", 64'(out_data_a), 64'(e.da));
                    chk("ovf_acc0", 64'(out_ovf_a), 64'(e.oa));
                    if (out_ready) void'(sb.pop_front());
                end
                if (!out_ready) chk("in_ready_stalled", 64'(in_ready), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit got;
        vectors     = 0;
        miscompares = 0;
        rdy_mode    = 0;
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_ovf", 64'(out_ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Max operands, single beat, with latency and one-cycle valid check
        send_beat(fill(13'h1FFF), 1'b1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = out_valid;
        end
        chk("latency", 64'(n), 64'd5);
        @(negedge clk);
        chk("valid_one_cycle", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Three-beat packet of ones
        for (int b = 0; b < 3; b++) send_beat(fill(13'd1), b == 2);
        drain();

        // Most negative signed operand
        send_beat(fill(13'h1000), 1'b1);
        drain();

        // Zero-headroom overflow, then a clean packet
        send_beat(fill(13'h1FFF), 1'b0);
        send_beat(fill(13'h1FFF), 1'b1);
        send_beat(fill(13'd3), 1'b1);
        drain();

        // Back-to-back packets with a three-cycle output stall
        fork
            begin
                for (int k = 1; k <= 10; k++) send_beat(fill(AW'(k)), 1'b1);
            end
            begin
                repeat (6) @(posedge clk);
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Reset in the middle of a packet
        send_beat(rand_data(), 1'b0);
        send_beat(rand_data(), 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send_beat(fill(13'd2), 1'b1);
        drain();

        // Random packets with random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) send_beat(rand_data(), b == len - 1);
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
